uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` serializer between `NUM_REQ` byte sources. It accepts bytes over per-requester valid/ready handshakes and issues one-cycle `tx_start` pulses with stable `tx_data`. It tracks `tx_busy` to sequence bytes, and holds the grant across multi-byte messages until the requester marks the last byte. It sits between the application/command logic and `uart_tx` in the 12 MHz domain.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM encoding, data width, default busy timeout.
package uart_arb_pkg;

  localparam int unsigned UART_DATA_W       = 8;
  localparam int unsigned BUSY_WAIT_DEFAULT = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StStart    = 3'd2,
    StWaitBusy = 3'd3,
    StWaitDone = 3'd4,
    StLocked   = 3'd5
  } arb_state_e;

  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap-around.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_pick;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  assign w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
  assign w_pick  = w_rot & (~w_rot + NUM_REQ'(1));
  assign o_grant = NUM_REQ'(({w_pick, w_pick} << i_ptr) >> NUM_REQ);
  assign o_valid = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_tx between NUM_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to abandon a byte when tx_busy never rises within BUSY_WAIT cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BUSY_WAIT = BUSY_WAIT_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         tx_start,
  output logic [UART_DATA_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic                         err_timeout
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_WAIT < 2) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and BUSY_WAIT at least 2");
  end

  arb_state_e               r_state;
  logic [NUM_REQ-1:0]       r_grant;
  logic [PTR_W-1:0]         r_rr_ptr;
  logic                     r_last;
  logic                     r_tx_start;
  logic [UART_DATA_W-1:0]   r_tx_data;

  logic [NUM_REQ-1:0]       w_pick;
  logic                     w_pick_valid;
  logic [UART_DATA_W-1:0]   w_sel_data;
  logic                     w_sel_last;
  logic [PTR_W-1:0]         w_gidx;
  logic [PTR_W-1:0]         w_next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_sel_data = w_sel_data | req_data[UART_DATA_W*i +: UART_DATA_W];
        w_sel_last = w_sel_last | req_last[i];
      end
    end
  end

  // Released owner drops to lowest priority by moving the pointer just past it.
  assign w_gidx     = PTR_W'(oh_to_idx(8'(r_grant)));
  assign w_next_ptr = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(BUSY_WAIT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  assign err_timeout = r_err;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_last     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          // Never start over a frame still shifting (e.g. after a reset mid-frame).
          if (!tx_busy && w_pick_valid) begin
            r_grant <= w_pick;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          r_tx_data  <= w_sel_data;
          r_last     <= w_sel_last;
          r_tx_start <= 1'b1;
          r_state    <= StStart;
        end
        StStart: begin
`ifdef UART_ARB_TIMEOUT_EN
          r_cnt   <= CNT_W'(1);
`endif
          r_state <= StWaitBusy;
        end
        StWaitBusy: begin
          if (tx_busy) begin
            r_state <= StWaitDone;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (r_cnt == CNT_W'(BUSY_WAIT - 1)) begin
            r_err    <= 1'b1;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= StIdle;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
`endif
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            if (r_last) begin
              r_rr_ptr <= w_next_ptr;
              r_grant  <= '0;
              r_state  <= StIdle;
            end else begin
              r_state <= StLocked;
            end
          end
        end
        StLocked: begin
          if (|(req_valid & r_grant)) r_state <= StLoad;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = (r_state == StLoad) ? r_grant : '0;
  assign grant     = r_grant;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a uart_tx busy model and a message-level RR model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int BW = 8;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic           err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ   (N),
    .BUSY_WAIT (BW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .err_timeout (err_timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [7:0] d; logic last;} drv_t;
  typedef struct {int r; logic [7:0] d; bit cont;} exp_t;

  drv_t stage[N][$];
  drv_t drvq[N][$];
  exp_t expq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int m_ptr = 0;
  int busy_len = 20;
  bit never_busy = 1'b0;
  int fall_cyc = -100;
  logic busy_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Requester drivers: hold valid/data until the handshake cycle has passed.
  initial begin
    logic [N-1:0] hs;
    forever begin
      @(negedge CLK);
      hs = req_valid & req_ready;
      @(posedge CLK);
      #1;
      for (int g = 0; g < N; g++) begin
        if (hs[g] && drvq[g].size() > 0) void'(drvq[g].pop_front());
        if (drvq[g].size() > 0) begin
          req_valid[g]         = 1'b1;
          req_data[8*g +: 8]   = drvq[g][0].d;
          req_last[g]          = drvq[g][0].last;
        end else begin
          req_valid[g] = 1'b0;
          req_last[g]  = 1'b0;
        end
      end
    end
  end

  // uart_tx model: busy rises one cycle after start and holds for busy_len cycles.
  initial forever begin
    @(negedge CLK);
    if (tx_start === 1'b1 && !never_busy) begin
      int len;
      len = busy_len;
      @(posedge CLK);
      #1 tx_busy = 1'b1;
      repeat (len) @(posedge CLK);
      #1 tx_busy = 1'b0;
    end
  end

  // Monitor: every start pops one expected byte.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (busy_prev && !tx_busy) fall_cyc = cyc;
      busy_prev = tx_busy;
      if (tx_start === 1'b1) begin
        chk("start_on_idle_line", 64'(tx_busy), 64'd0);
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_start: got start with data 0x%0h, want no start", tx_data);
        end else begin
          e = expq.pop_front();
          chk("tx_data", 64'(tx_data), 64'(e.d));
          chk("grant_owner", 64'(grant), 64'(1 << e.r));
          if (e.cont) chk("locked_gap", 64'(cyc - fall_cyc), 64'd3);
        end
      end
    end
  end

  task automatic stage_msg(input int r, input int len, input bit fixed, input logic [7:0] base);
    drv_t x;
    for (int j = 0; j < len; j++) begin
      x.d    = fixed ? base + 8'(j) : 8'($urandom);
      x.last = (j == len - 1);
      stage[r].push_back(x);
    end
  endtask

  // Model: all staged messages pending at once are served whole, in order from m_ptr upward.
  task automatic commit();
    int   last_w;
    exp_t e;
    last_w = -1;
    for (int k = 0; k < N; k++) begin
      int r;
      r = (m_ptr + k) % N;
      for (int j = 0; j < stage[r].size(); j++) begin
        e.r    = r;
        e.d    = stage[r][j].d;
        e.cont = (j > 0);
        expq.push_back(e);
        drvq[r].push_back(stage[r][j]);
        last_w = r;
      end
      stage[r].delete();
    end
    if (last_w >= 0) m_ptr = (last_w + 1) % N;
  endtask

  function automatic bit all_idle();
    bit ok;
    ok = (expq.size() == 0) && (grant == '0) && !tx_busy && (req_valid == '0);
    for (int g = 0; g < N; g++) if (drvq[g].size() != 0) ok = 1'b0;
    return ok;
  endfunction

  task automatic drain(input string nm, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (all_idle()) break;
    end
    chk({nm, "_drain"}, 64'(i < budget), 64'd1);
  endtask

  task automatic wait_start(input string nm, output int c);
    int i;
    c = -1;
    for (i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (tx_start === 1'b1) begin
        c = cyc;
        break;
      end
    end
    chk({nm, "_start_seen"}, 64'(i < 100), 64'd1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_grant"}, 64'(grant), 64'd0);
    chk({nm, "_ready"}, 64'(req_ready), 64'd0);
    chk({nm, "_tx_start"}, 64'(tx_start), 64'd0);
    chk({nm, "_tx_data"}, 64'(tx_data), 64'd0);
    chk({nm, "_err"}, 64'(err_timeout), 64'd0);
  endtask

  initial begin
    int c0, rdy_c, st_c, errs, err_c, i;
    bit seen;

    repeat (3) @(negedge CLK);
    chk_reset_vals("reset");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Contention: all four at once from pointer 0, then requester 0 alone.
    for (int r = 0; r < N; r++) stage_msg(r, 1, 1'b1, 8'h10 + 8'(r));
    commit();
    drain("contention", 400);
    stage_msg(0, 1, 1'b1, 8'hA5);
    commit();
    drain("rerequest", 200);

    // Single byte with long frame: latency and grant release.
    busy_len = 1042;
    stage_msg(0, 1, 1'b1, 8'h48);
    commit();
    c0 = cyc;
    rdy_c = -1;
    st_c = -1;
    for (i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rdy_c < 0 && req_ready[0]) rdy_c = cyc;
      if (st_c < 0 && tx_start) st_c = cyc;
      if (st_c >= 0) break;
    end
    chk("ready_latency", 64'(rdy_c - c0), 64'd2);
    chk("start_latency", 64'(st_c - c0), 64'd3);
    seen = 1'b0;
    for (i = 0; i < 1200; i++) begin
      @(negedge CLK);
      if (seen && !tx_busy) break;
      if (tx_busy) seen = 1'b1;
    end
    chk("grant_held_at_fall", 64'(grant), 64'd1);
    @(negedge CLK);
    chk("grant_cleared", 64'(grant), 64'd0);
    drain("single", 50);
    busy_len = 20;

    // Requester 1 moves the pointer to 2; then a locked message from 2 against a waiting 1.
    stage_msg(1, 1, 1'b0, 8'h00);
    commit();
    drain("ptr_setup", 200);
    stage_msg(2, 3, 1'b1, 8'h41);
    stage_msg(1, 1, 1'b1, 8'h55);
    commit();
    drain("locked", 400);

    // Randomized rounds.
    for (int rnd = 0; rnd < 10; rnd++) begin
      busy_len = $urandom_range(1, 12);
      seen = 1'b0;
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          stage_msg(r, $urandom_range(1, 3), 1'b0, 8'h00);
          seen = 1'b1;
        end
      end
      if (!seen) stage_msg($urandom_range(0, N - 1), $urandom_range(1, 3), 1'b0, 8'h00);
      commit();
      drain("random", 1000);
    end

    // Reset while the frame is still shifting.
    busy_len = 600;
    stage_msg(3, 1, 1'b1, 8'h77);
    commit();
    for (i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (tx_busy) break;
    end
    repeat (100) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_reset_vals("midframe_reset");
    RST = 1'b0;
    m_ptr = 0;
    busy_len = 20;
    stage_msg(2, 1, 1'b1, 8'h62);
    stage_msg(0, 1, 1'b1, 8'h60);
    commit();
    drain("after_reset", 900);

    // Serializer that never goes busy.
    never_busy = 1'b1;
    stage_msg(1, 1, 1'b1, 8'h31);
    commit();
    wait_start("timeout", c0);
    errs = 0;
    err_c = -1;
`ifdef UART_ARB_TIMEOUT_EN
    for (i = 0; i < 3 * BW; i++) begin
      @(negedge CLK);
      if (err_timeout) begin
        errs++;
        if (err_c < 0) begin
          err_c = cyc;
          chk("timeout_grant_released", 64'(grant), 64'd0);
        end
      end
    end
    chk("timeout_pulses", 64'(errs), 64'd1);
    chk("timeout_cycle", 64'(err_c - c0), 64'(BW));
    never_busy = 1'b0;
    stage_msg(1, 1, 1'b1, 8'h32);
    stage_msg(2, 1, 1'b1, 8'h33);
    commit();
    drain("after_timeout", 300);
`else
    for (i = 0; i < 3 * BW + 10; i++) begin
      @(negedge CLK);
      if (err_timeout) errs++;
    end
    chk("no_timeout_pulses", 64'(errs), 64'd0);
    chk("stuck_grant", 64'(grant), 64'b0010);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("stuck_reset_grant", 64'(grant), 64'd0);
    never_busy = 1'b0;
    m_ptr = 0;
`endif

    repeat (5) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
